// File: rtl/johnson_decoder.sv
// Johnson-code phase decoder with sequence checking and lock detection.
// Decodes a 4-stage Johnson code (shift right, inverted LSB into MSB) into a
// 3-bit phase. Each valid sample is classified as illegal, a hold, a +1 step
// or an out-of-order jump. A run of LOCK_CNT consecutive steps moves the
// tracker from SEARCH to LOCKED. All outputs are registered with a latency
// of one cycle.
module johnson_decoder #(
  parameter int unsigned LOCK_CNT = 3  // steps needed to lock, 1..7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [3:0] in_code,
  output logic       out_valid,
  output logic [2:0] phase,
  output logic       illegal_code,
  output logic       seq_error,
  output logic       locked,
  output logic [7:0] err_count
);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [2:0] LOCK_TGT = 3'(LOCK_CNT);

  state_e     state_q, state_d;
  logic [2:0] lock_cnt_q, lock_cnt_d;
  logic       has_prev_q, has_prev_d;
  logic [2:0] prev_phase_q, prev_phase_d;
  logic       out_valid_q, out_valid_d;
  logic [2:0] phase_q, phase_d;
  logic       illegal_q, illegal_d;
  logic       seq_err_q, seq_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic       code_legal;
  logic [2:0] code_phase;
  logic [2:0] next_phase;
  logic [2:0] lock_cnt_inc;

  // Map the incoming code onto its phase index and flag unknown patterns.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    code_legal = 1'b1;
    code_phase = 3'd0;
    unique case (in_code)
      4'b0000: code_phase = 3'd0;
      4'b1000: code_phase = 3'd1;
      4'b1100: code_phase = 3'd2;
      4'b1110: code_phase = 3'd3;
      4'b1111: code_phase = 3'd4;
      4'b0111: code_phase = 3'd5;
      4'b0011: code_phase = 3'd6;
      4'b0001: code_phase = 3'd7;
      default: code_legal = 1'b0;
    endcase
  end

  // Classify the sample, advance the lock tracker and compute next outputs.
  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    has_prev_d   = has_prev_q;
    prev_phase_d = prev_phase_q;
    out_valid_d  = in_valid;
    phase_d      = phase_q;
    illegal_d    = 1'b0;
    seq_err_d    = 1'b0;
    err_cnt_d    = err_cnt_q;

    // 3-bit arithmetic gives the 7 -> 0 wrap for free.
    next_phase   = prev_phase_q + 3'd1;
    lock_cnt_inc = lock_cnt_q + 3'd1;

    if (in_valid) begin
      if (!code_legal) begin
        // Illegal code breaks the chain: forget the previous phase too.
        illegal_d  = 1'b1;
        phase_d    = 3'd0;
        has_prev_d = 1'b0;
        lock_cnt_d = 3'd0;
        state_d    = SEARCH;
      end else begin
        phase_d      = code_phase;
        prev_phase_d = code_phase;
        has_prev_d   = 1'b1;
        if (!has_prev_q) begin
          // First legal sample after reset or an illegal code: no reference.
          lock_cnt_d = 3'd0;
        end else if (code_phase == prev_phase_q) begin
          // Hold: counter and state stay as they are.
        end else if (code_phase == next_phase) begin
          if (lock_cnt_q != LOCK_TGT) begin
            lock_cnt_d = lock_cnt_inc;
          end
          if (state_q == SEARCH && lock_cnt_inc == LOCK_TGT) begin
            state_d = LOCKED;
          end
        end else begin
          seq_err_d  = 1'b1;
          lock_cnt_d = 3'd0;
          state_d    = SEARCH;
        end
      end

      if ((illegal_d || seq_err_d) && err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    if (!reset_n) begin
      state_q      <= SEARCH;
      lock_cnt_q   <= 3'd0;
      has_prev_q   <= 1'b0;
      prev_phase_q <= 3'd0;
      out_valid_q  <= 1'b0;
      phase_q      <= 3'd0;
      illegal_q    <= 1'b0;
      seq_err_q    <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      has_prev_q   <= has_prev_d;
      prev_phase_q <= prev_phase_d;
      out_valid_q  <= out_valid_d;
      phase_q      <= phase_d;
      illegal_q    <= illegal_d;
      seq_err_q    <= seq_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign phase        = phase_q;
  assign illegal_code = illegal_q;
  assign seq_error    = seq_err_q;
  assign locked       = (state_q == LOCKED);
  assign err_count    = err_cnt_q;

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 3: number of consecutive +1 steps required to reach LOCKED (range 1..7).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: in_code is sampled on this cycle.
REQ-005 SHALL have port in_code, input, 4: 4-stage Johnson code from the team's shift-right/invert-LSB-into-MSB counter.
REQ-006 SHALL have port out_valid, output, 1: registered copy of in_valid.
REQ-007 SHALL have port phase, output, 3: decoded phase index.
REQ-008 SHALL have port illegal_code, output, 1: the sampled code is not one of the 8 legal codes.
REQ-009 SHALL have port seq_error, output, 1: the sampled code is legal but is neither a hold nor a +1 step.
REQ-010 SHALL have port locked, output, 1: the state machine is in LOCKED.
REQ-011 SHALL have port err_count, output, 8: saturating count of error events.

Function
REQ-012 SHALL decode 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7; all other codes are illegal.
REQ-013 SHALL register all outputs; the response to a sample taken at edge N appears after edge N, with 1-cycle latency.
REQ-014 SHALL, when in_valid=0, drive out_valid=0, illegal_code=0 and seq_error=0, and hold phase, locked, err_count and all internal state.
REQ-015 SHALL, for an illegal code, drive phase=0 and illegal_code=1, and clear the internal has_prev flag.
REQ-016 SHALL, for a legal code with has_prev=1, treat code==prev as a hold: no error, lock counter unchanged.
REQ-017 SHALL, for a legal code with has_prev=1, treat phase==(prev_phase+1) mod 8 as a step: no error, lock counter +1.
REQ-018 SHALL, for a legal code with has_prev=1, treat any other phase as seq_error=1 and clear the lock counter.
REQ-019 SHALL, for a legal code with has_prev=0, raise no error and leave the lock counter at 0.
REQ-020 SHALL, for any legal code, store prev_phase and set has_prev=1.
REQ-021 SHALL wrap phase 7 -> 0 as a legal step.
REQ-022 SHALL implement FSM SEARCH -> LOCKED when the lock counter reaches LOCK_CNT on a step.
REQ-023 SHALL implement FSM LOCKED -> SEARCH on illegal_code or seq_error, clearing the lock counter.
REQ-024 SHALL keep LOCKED unchanged on holds and steps while in LOCKED.
REQ-025 SHALL clear the lock counter on illegal_code in SEARCH; the lock counter saturates at LOCK_CNT.
REQ-026 SHALL increment err_count by 1 on each cycle where illegal_code or seq_error is set, in either state, saturating at 255.
REQ-027 SHALL never assert illegal_code and seq_error together.

Reset
REQ-028 SHALL, on reset_n=0 at a rising clk edge, set state=SEARCH, lock counter=0, has_prev=0, prev_phase=0, out_valid=0, phase=0, illegal_code=0, seq_error=0, locked=0 and err_count=0.
REQ-029 SHALL give reset priority over in_valid, including mid-sequence and while LOCKED, and SHALL ignore the sample presented in the reset cycle.

Verification
REQ-030 SHALL cover this scenario: reset, then codes 0000, 1000, 1100, 1110 with in_valid=1 every cycle -> phase 0, 1, 2, 3; locked=1 on the 4th output (3 steps); err_count=0.
REQ-031 SHALL cover this scenario: once locked, codes 0001 then 0000 -> phase 7 then 0, no error, locked stays 1.
REQ-032 SHALL cover this scenario: once locked at phase 2, code 1010 -> illegal_code=1, phase=0, locked=0, err_count=1; the next code 1111 raises no seq_error.
REQ-033 SHALL cover this scenario: once locked at phase 3, code 0111 (phase 5) -> seq_error=1, locked=0, err_count increments; then 0011, 0001, 0000 -> relocked.
REQ-034 SHALL cover this scenario: a repeated hold code plus in_valid gaps between steps -> no errors, lock counter advances only on steps, outputs hold during gaps.
REQ-035 SHALL cover this scenario: 300 illegal samples -> err_count saturates at 255; a reset_n pulse mid-stream while LOCKED -> all outputs 0 on the next cycle.
